dbus_bridge: RTL and testbench
==============================

DBUS_BRIDGE -- requirements
Module: dbus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, WAIT cycles without ack before forced termination (range 1..255).
REQ-002 SHALL have ports in this order:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_ce  in  1  global clock enable.
- i_hold  in  1  other CPU stall source, e.g. ALU busy; tie 0 if unused.
- o_cpu_ce  out  1  clock enable to CPU.
- i_cpu_addr  in  32  memory-access stage address.
- i_cpu_wr_data  in  32  store data.
- i_cpu_wr  in  4  ungated byte write request.
- i_cpu_rd  in  1  ungated read request.
- o_cpu_rd_data  out  32  load data.
- o_bus_req  out  1  external request.
- o_bus_we  out  1  write (1) / read (0).
- o_bus_addr  out  32  external address.
- o_bus_be  out  4  byte enables.
- o_bus_wr_data  out  32  external write data.
- i_bus_ack  in  1  transfer complete.
- i_bus_rd_data  in  32  read data, valid with ack.
- o_bus_err  out  1  one-cycle timeout pulse.
REQ-003 i_cpu_rd and i_cpu_wr SHALL NOT depend combinationally on o_cpu_ce.

Function
REQ-004 SHALL implement FSM IDLE, WAIT, DONE.
REQ-005 IDLE: o_cpu_ce = i_ce & ~i_hold & ~(i_cpu_rd | |i_cpu_wr).
REQ-006 IDLE, i_ce=1, request present: latch addr, wr_data, be, we; next state WAIT; o_bus_req=1 from the next cycle.
REQ-007 Request with i_ce=0 SHALL be ignored until i_ce=1.
REQ-008 i_cpu_rd and i_cpu_wr both set: treat as write (we=1, be=i_cpu_wr).
REQ-009 Read: o_bus_be=4'hF, o_bus_we=0.
REQ-010 WAIT: o_cpu_ce=0; o_bus_req and all o_bus_* outputs held stable.
REQ-011 WAIT, i_bus_ack=1: read captures i_bus_rd_data into o_cpu_rd_data; deassert req; next state DONE.
REQ-012 DONE: o_cpu_ce = i_ce & ~i_hold; leave for IDLE only when that is 1; otherwise stay, holding o_cpu_rd_data.
REQ-013 Zero-wait ack, i.e. ack in the first WAIT cycle, SHALL give request-to-release of 3 cycles: 2 stall cycles, CPU advances at the DONE edge.
REQ-014 i_bus_ack outside WAIT SHALL be ignored.
REQ-015 Writes SHALL NOT modify o_cpu_rd_data.

Reset
REQ-016 i_rst SHALL force IDLE; o_bus_req, o_bus_we, o_bus_err = 0; o_bus_addr, o_bus_be, o_bus_wr_data, o_cpu_rd_data = 0; timeout counter = 0.
REQ-017 Reset in WAIT or DONE SHALL abort with no err pulse; req low after that edge.

Configuration
REQ-018 Macro DBUS_TIMEOUT_EN defined: 8-bit counter cleared on WAIT entry and incremented per WAIT cycle without ack.
- On reaching TIMEOUT: o_cpu_rd_data=32'hFFFF_FFFF for reads, o_bus_err=1 for one cycle, go DONE.
- Ack in the same cycle wins, with no err.
REQ-019 Macro undefined: no counter, WAIT indefinite, o_bus_err tied 0, TIMEOUT unused.

Structure
REQ-020 Package dbus_pkg SHALL hold state encoding, ERR_DATA=32'hFFFF_FFFF and counter width constant.
REQ-021 Timeout counter SHALL be sub-module dbus_timeout, instantiated only under DBUS_TIMEOUT_EN.

Verification
REQ-022 Read 0x100, ack in 1st WAIT cycle, data 0xDEADBEEF -> o_cpu_ce low 2 cycles; DONE shows 0xDEADBEEF, o_cpu_ce=1.
REQ-023 Write be=4'b0011, data 0x1234 to 0x204, ack after 5 cycles -> req high 5 cycles, addr/be/data stable, o_cpu_rd_data unchanged.
REQ-024 DBUS_TIMEOUT_EN, TIMEOUT=4, no ack -> after 4 WAIT cycles o_bus_err pulses once, read data 0xFFFFFFFF; ack on 4th cycle instead -> bus data, no err.
REQ-025 i_hold=1 in DONE for 3 cycles -> DONE held, data stable, o_cpu_ce=0; release -> IDLE next edge.
REQ-026 i_rst mid-WAIT, then stray ack -> IDLE, req=0, err=0, ack ignored.

Source files
------------

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared state encoding and constants for the CPU data-bus bridge
package dbus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;
   localparam int          CNT_W    = 8;

endpackage

// File: rtl/dbus_timeout.sv
// rtl/dbus_timeout.sv - WAIT-cycle counter that flags expiry on the TIMEOUT-th unacked cycle
module dbus_timeout
   import dbus_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q counts completed unacked cycles, so TIMEOUT-1 means this is the TIMEOUT-th one
   assign o_expired = i_inc && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - stalls the CPU while one load/store runs on the external bus; DBUS_TIMEOUT_EN adds a WAIT timeout
module dbus_bridge
   import dbus_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ce,
   input  logic        i_hold,
   output logic        o_cpu_ce,
   input  logic [31:0] i_cpu_addr,
   input  logic [31:0] i_cpu_wr_data,
   input  logic [3:0]  i_cpu_wr,
   input  logic        i_cpu_rd,
   output logic [31:0] o_cpu_rd_data,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [3:0]  o_bus_be,
   output logic [31:0] o_bus_wr_data,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rd_data,
   output logic        o_bus_err
);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic [3:0]  be_q, be_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic        cpu_req;
   logic        expired;

   assign cpu_req = i_cpu_rd | (|i_cpu_wr);

`ifdef DBUS_TIMEOUT_EN
   dbus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (state_q != ST_WAIT),
      .i_inc     ((state_q == ST_WAIT) && !i_bus_ack),
      .o_expired (expired)
   );
`else
   localparam int unused_timeout = TIMEOUT;
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      rd_data_d = rd_data_q;
      be_d      = be_q;
      we_d      = we_q;
      err_d     = 1'b0;
      o_cpu_ce  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_cpu_ce = i_ce & ~i_hold & ~cpu_req;
            if (i_ce && cpu_req) begin
               // a simultaneous read and write request is carried out as the write
               addr_d    = i_cpu_addr;
               wr_data_d = i_cpu_wr_data;
               we_d      = |i_cpu_wr;
               be_d      = (|i_cpu_wr) ? i_cpu_wr : 4'hF;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_bus_ack) begin
               if (!we_q) rd_data_d = i_bus_rd_data;
               state_d = ST_DONE;
            end else if (expired) begin
               if (!we_q) rd_data_d = ERR_DATA;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            o_cpu_ce = i_ce & ~i_hold;
            if (i_ce && !i_hold) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wr_data_q <= '0;
         rd_data_q <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         rd_data_q <= rd_data_d;
         be_q      <= be_d;
         we_q      <= we_d;
         err_q     <= err_d;
      end
   end

   assign o_bus_req     = (state_q == ST_WAIT);
   assign o_bus_we      = we_q;
   assign o_bus_addr    = addr_q;
   assign o_bus_be      = be_q;
   assign o_bus_wr_data = wr_data_q;
   assign o_cpu_rd_data = rd_data_q;
   assign o_bus_err     = err_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - directed and randomized transaction checks of dbus_bridge against a transaction-level model
module tb_dbus_bridge;

   localparam int TO = 4;
`ifdef DBUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_ce;
   logic        i_hold;
   logic        o_cpu_ce;
   logic [31:0] i_cpu_addr;
   logic [31:0] i_cpu_wr_data;
   logic [3:0]  i_cpu_wr;
   logic        i_cpu_rd;
   logic [31:0] o_cpu_rd_data;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [3:0]  o_bus_be;
   logic [31:0] o_bus_wr_data;
   logic        i_bus_ack;
   logic [31:0] i_bus_rd_data;
   logic        o_bus_err;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] model_rd;

   dbus_bridge #(.TIMEOUT(TO)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_ce          (i_ce),
      .i_hold        (i_hold),
      .o_cpu_ce      (o_cpu_ce),
      .i_cpu_addr    (i_cpu_addr),
      .i_cpu_wr_data (i_cpu_wr_data),
      .i_cpu_wr      (i_cpu_wr),
      .i_cpu_rd      (i_cpu_rd),
      .o_cpu_rd_data (o_cpu_rd_data),
      .o_bus_req     (o_bus_req),
      .o_bus_we      (o_bus_we),
      .o_bus_addr    (o_bus_addr),
      .o_bus_be      (o_bus_be),
      .o_bus_wr_data (o_bus_wr_data),
      .i_bus_ack     (i_bus_ack),
      .i_bus_rd_data (i_bus_rd_data),
      .o_bus_err     (o_bus_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One CPU access: request in IDLE, WAIT until ack (index `delay`) or timeout, then DONE
   // held for `hold` cycles, then back to IDLE. Expectations come from the transaction only.
   task automatic txn(input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                      input int hold);
      logic        exp_we;
      logic [3:0]  exp_be;
      bit          timed_out;
      int          n_wait;
      exp_we    = |wr;
      exp_be    = exp_we ? wr : 4'hF;
      timed_out = TO_EN && (delay >= TO);
      n_wait    = timed_out ? TO : delay + 1;

      @(negedge i_clk);
      i_ce = 1'b1; i_hold = 1'b0;
      i_cpu_rd = rd; i_cpu_wr = wr; i_cpu_addr = addr; i_cpu_wr_data = wdata;
      #1;
      chk("idle_req_stall", o_cpu_ce, 0);
      chk("idle_no_bus_req", o_bus_req, 0);

      for (int c = 0; c < n_wait; c++) begin
         @(negedge i_clk);
         i_cpu_rd = 1'b0; i_cpu_wr = 4'h0;
         i_cpu_addr = $urandom; i_cpu_wr_data = $urandom;
         i_bus_ack = (c == delay);
         i_bus_rd_data = (c == delay) ? rdata : $urandom;
         #1;
         chk("wait_req", o_bus_req, 1);
         chk("wait_cpu_ce", o_cpu_ce, 0);
         chk("wait_addr", o_bus_addr, addr);
         chk("wait_we", o_bus_we, exp_we);
         chk("wait_be", o_bus_be, exp_be);
         chk("wait_wdata", o_bus_wr_data, wdata);
         chk("wait_err", o_bus_err, 0);
      end

      if (!exp_we) model_rd = timed_out ? 32'hFFFF_FFFF : rdata;

      @(negedge i_clk);
      i_bus_ack = 1'b0; i_bus_rd_data = $urandom;
      i_hold = (hold > 0);
      #1;
      chk("done_req", o_bus_req, 0);
      chk("done_rd_data", o_cpu_rd_data, model_rd);
      chk("done_err", o_bus_err, timed_out);
      chk("done_cpu_ce", o_cpu_ce, hold == 0);

      for (int h = 1; h <= hold; h++) begin
         @(negedge i_clk);
         i_hold = (h < hold);
         #1;
         chk("hold_cpu_ce", o_cpu_ce, h == hold);
         chk("hold_rd_data", o_cpu_rd_data, model_rd);
         chk("hold_err", o_bus_err, 0);
         chk("hold_req", o_bus_req, 0);
      end

      @(negedge i_clk);
      #1;
      chk("back_idle_cpu_ce", o_cpu_ce, 1);
      chk("back_idle_req", o_bus_req, 0);
   endtask

   initial begin
      logic [3:0] m;
      bit         r;
      i_rst = 1'b1; i_ce = 1'b1; i_hold = 1'b0;
      i_cpu_addr = '0; i_cpu_wr_data = '0; i_cpu_wr = '0; i_cpu_rd = 1'b0;
      i_bus_ack = 1'b0; i_bus_rd_data = '0;
      model_rd = '0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      chk("rst_req", o_bus_req, 0);
      chk("rst_we", o_bus_we, 0);
      chk("rst_err", o_bus_err, 0);
      chk("rst_addr", o_bus_addr, 0);
      chk("rst_be", o_bus_be, 0);
      chk("rst_wdata", o_bus_wr_data, 0);
      chk("rst_rd_data", o_cpu_rd_data, 0);
      chk("rst_cpu_ce", o_cpu_ce, 1);

      // request while i_ce=0 is ignored
      @(negedge i_clk);
      i_ce = 1'b0; i_cpu_rd = 1'b1; i_cpu_addr = 32'h55;
      #1 chk("noce_cpu_ce", o_cpu_ce, 0);
      @(negedge i_clk);
      #1 chk("noce_req", o_bus_req, 0);
      @(negedge i_clk);
      #1 chk("noce_req2", o_bus_req, 0);
      i_cpu_rd = 1'b0; i_ce = 1'b1;

      // ack outside WAIT is ignored
      @(negedge i_clk);
      i_bus_ack = 1'b1; i_bus_rd_data = 32'hBAD0_BAD0;
      @(negedge i_clk);
      i_bus_ack = 1'b0;
      #1;
      chk("stray_ack_req", o_bus_req, 0);
      chk("stray_ack_rd_data", o_cpu_rd_data, 0);
      chk("stray_ack_cpu_ce", o_cpu_ce, 1);

      txn(1'b1, 4'h0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0);
      txn(1'b0, 4'b0011, 32'h204, 32'h1234, 4, 32'hCAFE_0000, 0);
      txn(1'b1, 4'h0, 32'h300, 32'h0, 1, 32'h0BAD_F00D, 3);
      txn(1'b1, 4'b1000, 32'h404, 32'hA5A5_5A5A, 2, 32'h7777_7777, 0);
      if (TO_EN) begin
         txn(1'b1, 4'h0, 32'h500, 32'h0, 10, 32'h1111_2222, 0);
         txn(1'b1, 4'h0, 32'h504, 32'h0, TO - 1, 32'h3333_4444, 0);
         txn(1'b0, 4'b1111, 32'h508, 32'h9999_0000, 10, 32'h0, 1);
      end

      for (int k = 0; k < 24; k++) begin
         r = 1'($urandom_range(0, 1));
         m = 4'($urandom_range(1, 15));
         if (r && ($urandom_range(0, 2) != 0)) m = 4'h0;
         txn(r, m, $urandom, $urandom, $urandom_range(0, 5), $urandom, $urandom_range(0, 2));
      end

      // reset in the middle of WAIT, then a stray ack
      @(negedge i_clk);
      i_cpu_rd = 1'b1; i_cpu_addr = 32'h600;
      @(negedge i_clk);
      i_cpu_rd = 1'b0;
      #1 chk("rstwait_req_before", o_bus_req, 1);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0; i_bus_ack = 1'b1; i_bus_rd_data = 32'hFEED_FACE;
      model_rd = '0;
      #1;
      chk("rstwait_req", o_bus_req, 0);
      chk("rstwait_err", o_bus_err, 0);
      chk("rstwait_cpu_ce", o_cpu_ce, 1);
      chk("rstwait_rd_data", o_cpu_rd_data, 0);
      @(negedge i_clk);
      i_bus_ack = 1'b0;
      #1;
      chk("rstwait_ack_ignored", o_cpu_rd_data, 0);
      chk("rstwait_req_after", o_bus_req, 0);
      chk("rstwait_err_after", o_bus_err, 0);

      txn(1'b1, 4'h0, 32'h700, 32'h0, 0, 32'h2468_ACE0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
